// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcodes, status flag positions and FSM states shared by the ALU sequencer
package alu_pkg;

   typedef enum logic [4:0] {
      OP_INC = 5'b00001,
      OP_DEC = 5'b00011,
      OP_ADD = 5'b00100,
      OP_ADC = 5'b00101,
      OP_SUB = 5'b00110,
      OP_SBB = 5'b00111,
      OP_AND = 5'b01000,
      OP_OR  = 5'b01001,
      OP_XOR = 5'b01010,
      OP_NOT = 5'b01011,
      OP_SHL = 5'b10000,
      OP_SHR = 5'b10001,
      OP_SAL = 5'b10010,
      OP_SAR = 5'b10011,
      OP_ROL = 5'b10100,
      OP_ROR = 5'b10101,
      OP_RCL = 5'b10110,
      OP_RCR = 5'b10111
   } op_e;

   localparam int CF_BIT = 5;
   localparam int ZF_BIT = 4;
   localparam int NF_BIT = 3;
   localparam int VF_BIT = 2;
   localparam int PF_BIT = 1;
   localparam int AF_BIT = 0;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_EXEC  = 2'd1,
      S_SHIFT = 2'd2,
      S_DONE  = 2'd3
   } state_e;

   // Every 10xxx code is a shift/rotate; the low three bits select the kind.
   function automatic logic is_shift(input logic [4:0] f);
      return f[4:3] == 2'b10;
   endfunction

endpackage

// File: rtl/alu_shift_step.sv
// rtl/alu_shift_step.sv - one-bit shift/rotate step with carry in/out
module alu_shift_step #(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] val,
   input  logic             cin,
   input  logic [2:0]       op,
   output logic [WIDTH-1:0] val_o,
   output logic             cout
);

   always_comb begin
      val_o = val;
      cout  = cin;
      case (op)
         3'b000, 3'b010: begin val_o = {val[WIDTH-2:0], 1'b0};       cout = val[WIDTH-1]; end
         3'b001:         begin val_o = {1'b0, val[WIDTH-1:1]};       cout = val[0];       end
         3'b011:         begin val_o = {val[WIDTH-1], val[WIDTH-1:1]}; cout = val[0];     end
         3'b100:         begin val_o = {val[WIDTH-2:0], val[WIDTH-1]}; cout = val[WIDTH-1]; end
         3'b101:         begin val_o = {val[0], val[WIDTH-1:1]};     cout = val[0];       end
         // RCL/RCR treat {carry, val} as a WIDTH+1 bit ring
         3'b110:         begin val_o = {val[WIDTH-2:0], cin};        cout = val[WIDTH-1]; end
         3'b111:         begin val_o = {cin, val[WIDTH-1:1]};        cout = val[0];       end
         default:        begin val_o = val;                          cout = cin;          end
      endcase
   end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - sequential ALU with valid/ready handshake and bit-serial shifter
module alu_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [4:0]       F,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] Result,
   output logic [5:0]       Status,
   output logic             out_err
);

   localparam int SHW = $clog2(WIDTH);

   state_e           state;
   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] b_r;
   logic [4:0]       f_r;
   logic [SHW-1:0]   cnt;
   logic             wc;

   logic [WIDTH-1:0] step_v;
   logic             step_c;

   alu_shift_step #(.WIDTH(WIDTH)) u_step (
      .val   (a_r),
      .cin   (wc),
      .op    (f_r[2:0]),
      .val_o (step_v),
      .cout  (step_c)
   );

   logic [WIDTH-1:0] ex_res;
   logic [5:0]       ex_st;
   logic             ex_err;
   logic [WIDTH-1:0] opb;
   logic [WIDTH-1:0] af_vec;
   logic [WIDTH:0]   wide;
   logic             cy_in;
   logic             is_sub;

   always_comb begin
      ex_res = '0;
      ex_st  = Status;
      ex_err = 1'b0;
      opb    = (f_r == OP_INC || f_r == OP_DEC) ? WIDTH'(1) : b_r;
      cy_in  = (f_r == OP_ADC || f_r == OP_SBB) ? Status[CF_BIT] : 1'b0;
      is_sub = (f_r == OP_DEC || f_r == OP_SUB || f_r == OP_SBB);
      // The extra top bit of the wide result is the carry, or the borrow for subtraction
      wide   = is_sub ? ({1'b0, a_r} - {1'b0, opb} - (WIDTH+1)'(cy_in))
                      : ({1'b0, a_r} + {1'b0, opb} + (WIDTH+1)'(cy_in));
      af_vec = '0;
      case (f_r)
         OP_INC, OP_DEC, OP_ADD, OP_ADC, OP_SUB, OP_SBB: begin
            ex_res         = wide[WIDTH-1:0];
            af_vec         = a_r ^ opb ^ ex_res;
            ex_st[CF_BIT]  = wide[WIDTH];
            ex_st[AF_BIT]  = af_vec[4];
            ex_st[VF_BIT]  = is_sub ? ((a_r[WIDTH-1] != opb[WIDTH-1]) && (ex_res[WIDTH-1] != a_r[WIDTH-1]))
                                    : ((a_r[WIDTH-1] == opb[WIDTH-1]) && (ex_res[WIDTH-1] != a_r[WIDTH-1]));
         end
         OP_AND: ex_res = a_r & b_r;
         OP_OR:  ex_res = a_r | b_r;
         OP_XOR: ex_res = a_r ^ b_r;
         OP_NOT: ex_res = ~a_r;
         OP_SHL, OP_SHR, OP_SAL, OP_SAR, OP_ROL, OP_ROR, OP_RCL, OP_RCR: ex_res = a_r;
         default: ex_err = 1'b1;
      endcase
      if (!ex_err) begin
         ex_st[ZF_BIT] = (ex_res == '0);
         ex_st[NF_BIT] = ex_res[WIDTH-1];
         ex_st[PF_BIT] = ~^ex_res;
      end
   end

   logic [5:0] sh_st;

   always_comb begin
      sh_st         = Status;
      sh_st[CF_BIT] = step_c;
      sh_st[ZF_BIT] = (step_v == '0);
      sh_st[NF_BIT] = step_v[WIDTH-1];
      sh_st[PF_BIT] = ~^step_v;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         Result    <= '0;
         Status    <= '0;
         out_err   <= 1'b0;
         cnt       <= '0;
         a_r       <= '0;
         b_r       <= '0;
         f_r       <= '0;
         wc        <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  a_r      <= A;
                  b_r      <= B;
                  f_r      <= F;
                  cnt      <= B[SHW-1:0];
                  wc       <= Status[CF_BIT];
                  in_ready <= 1'b0;
                  state    <= (is_shift(F) && B[SHW-1:0] != '0) ? S_SHIFT : S_EXEC;
               end
            end
            S_EXEC: begin
               Result    <= ex_res;
               Status    <= ex_st;
               out_err   <= ex_err;
               out_valid <= 1'b1;
               state     <= S_DONE;
            end
            S_SHIFT: begin
               a_r <= step_v;
               wc  <= step_c;
               cnt <= cnt - SHW'(1);
               // Final step lands straight in the output registers
               if (cnt == SHW'(1)) begin
                  Result    <= step_v;
                  Status    <= sh_st;
                  out_err   <= 1'b0;
                  out_valid <= 1'b1;
                  state     <= S_DONE;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - randomized self-checking bench for alu_seq against a behavioural model
module tb_alu_seq;
   import alu_pkg::*;

   localparam int W = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  A;
   logic [W-1:0]  B;
   logic [4:0]    F;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  Result;
   logic [5:0]    Status;
   logic          out_err;

   int            vectors = 0;
   int            miscompares = 0;
   int            edge_cnt = 0;

   logic          exp_pending = 1'b0;
   logic [15:0]   exp_res;
   logic [5:0]    exp_st;
   logic          exp_err;
   int            exp_lat;
   int            acc_edge;
   logic [5:0]    mst;
   logic          seen = 1'b0;

   alu_seq #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (A),
      .B         (B),
      .F         (F),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .Result    (Result),
      .Status    (Status),
      .out_err   (out_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: flags from plain integer arithmetic, shifts as whole-word rotations.
   task automatic model(input logic [15:0] a, input logic [15:0] b, input logic [4:0] f,
                        input logic [5:0] st, output logic [15:0] r, output logic [5:0] s,
                        output logic e, output int lat);
      int n, ua, ubx, ci, t, sa, sb, sv;
      logic [16:0] ring;
      logic [15:0] bx;
      logic arith, sub;
      s = st; e = 1'b0; r = '0; lat = 1;
      n = int'(b[3:0]);
      arith = 1'b0; sub = 1'b0; ci = 0; bx = b;
      case (f)
         5'b00001: begin arith = 1; bx = 16'd1; end
         5'b00011: begin arith = 1; sub = 1; bx = 16'd1; end
         5'b00100: arith = 1;
         5'b00101: begin arith = 1; ci = int'(st[5]); end
         5'b00110: begin arith = 1; sub = 1; end
         5'b00111: begin arith = 1; sub = 1; ci = int'(st[5]); end
         5'b01000: r = a & b;
         5'b01001: r = a | b;
         5'b01010: r = a ^ b;
         5'b01011: r = ~a;
         5'b10000, 5'b10010: begin r = a; if (n > 0) begin r = a << n; s[5] = a[16-n]; end end
         5'b10001: begin r = a; if (n > 0) begin r = a >> n; s[5] = a[n-1]; end end
         5'b10011: begin r = a; if (n > 0) begin r = $signed(a) >>> n; s[5] = a[n-1]; end end
         5'b10100: begin r = a; if (n > 0) begin r = (a << n) | (a >> (16 - n)); s[5] = r[0]; end end
         5'b10101: begin r = a; if (n > 0) begin r = (a >> n) | (a << (16 - n)); s[5] = r[15]; end end
         5'b10110: begin
            ring = {st[5], a};
            if (n > 0) ring = (ring << n) | (ring >> (17 - n));
            r = ring[15:0]; s[5] = ring[16];
         end
         5'b10111: begin
            ring = {st[5], a};
            if (n > 0) ring = (ring >> n) | (ring << (17 - n));
            r = ring[15:0]; s[5] = ring[16];
         end
         default: e = 1'b1;
      endcase
      if (f[4:3] == 2'b10 && n > 0) lat = n;
      if (arith) begin
         ua = int'(a); ubx = int'(bx);
         sa = $signed(a); sb = $signed(bx);
         if (sub) begin
            t = ua - ubx - ci; sv = sa - sb - ci;
            s[5] = (t < 0);
            s[0] = ((ua % 16) < (ubx % 16) + ci);
         end else begin
            t = ua + ubx + ci; sv = sa + sb + ci;
            s[5] = (t > 65535);
            s[0] = ((ua % 16) + (ubx % 16) + ci > 15);
         end
         r = t[15:0];
         s[2] = (sv > 32767 || sv < -32768);
      end
      if (e) r = '0;
      else begin
         s[4] = (r == 16'h0);
         s[3] = r[15];
         s[1] = ($countones(r) % 2 == 0);
      end
   endtask

   // Outputs must match the model on every cycle of an operation, including DONE stalls.
   always @(negedge clk) begin
      if (!exp_pending) seen = 1'b0;
      else if (!rst) begin
         if (out_valid) begin
            if (!seen) begin
               seen = 1'b1;
               chk("latency", 64'(edge_cnt - acc_edge), 64'(exp_lat));
            end
            chk("result", Result, exp_res);
            chk("status", Status, exp_st);
            chk("out_err", out_err, exp_err);
         end else begin
            chk("valid_late", 64'(edge_cnt - acc_edge < exp_lat), 1);
         end
         chk("in_ready_busy", in_ready, 0);
      end
   end

   task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic [4:0] f,
                        input int stall, output logic [15:0] gr, output logic [5:0] gs,
                        output logic ge, output int glat);
      int n;
      n = 0;
      while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
      chk("ready_timeout", in_ready, 1);
      A = a; B = b; F = f; in_valid = 1'b1;
      model(a, b, f, mst, exp_res, exp_st, exp_err, exp_lat);
      @(posedge clk); #1;
      acc_edge = edge_cnt; exp_pending = 1'b1; mst = exp_st; vectors++;
      A = 16'($urandom); B = 16'($urandom); F = 5'($urandom);
      n = 0;
      while (!out_valid && n < 40) begin @(posedge clk); #1; n++; end
      chk("done_timeout", out_valid, 1);
      glat = edge_cnt - acc_edge;
      gr = Result; gs = Status; ge = out_err;
      repeat (stall) begin @(posedge clk); #1; end
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0; exp_pending = 1'b0;
      chk("in_ready_after_done", in_ready, 1);
      chk("valid_dropped", out_valid, 0);
   endtask

   logic [4:0] legal_ops [18] = '{5'h01, 5'h03, 5'h04, 5'h05, 5'h06, 5'h07, 5'h08, 5'h09, 5'h0A,
                                  5'h0B, 5'h10, 5'h11, 5'h12, 5'h13, 5'h14, 5'h15, 5'h16, 5'h17};
   logic [4:0] bad_ops [6] = '{5'h00, 5'h02, 5'h0C, 5'h0F, 5'h18, 5'h1F};

   initial begin
      logic [15:0] gr;
      logic [5:0]  gs;
      logic        ge;
      int          glat;
      logic [4:0]  fop;

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0; F = '0; mst = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_result", Result, 0);
      chk("rst_status", Status, 0);
      chk("rst_err", out_err, 0);
      chk("rst_in_ready", in_ready, 1);

      do_op(16'h7FFF, 16'h0001, OP_ADD, 0, gr, gs, ge, glat);
      chk("add_result", gr, 16'h8000);
      chk("add_status", gs, 6'b001101);
      chk("add_latency", glat, 1);

      do_op(16'h1234, 16'h0042, 5'b11111, 0, gr, gs, ge, glat);
      chk("illegal_result", gr, 16'h0000);
      chk("illegal_status", gs, 6'b001101);
      chk("illegal_err", ge, 1);

      do_op(16'h0000, 16'h0001, OP_SUB, 0, gr, gs, ge, glat);
      chk("sub_result", gr, 16'hFFFF);
      chk("sub_status", gs, 6'b101011);
      chk("sub_err", ge, 0);

      do_op(16'h0000, 16'h0000, OP_ADC, 0, gr, gs, ge, glat);
      chk("adc_result", gr, 16'h0001);
      chk("adc_cf", gs[5], 0);

      do_op(16'h8001, 16'h0004, OP_ROL, 0, gr, gs, ge, glat);
      chk("rol_result", gr, 16'h0018);
      chk("rol_cf", gs[5], 0);
      chk("rol_latency", glat, 4);

      do_op(16'h1234, 16'h4321, OP_ADD, 3, gr, gs, ge, glat);
      chk("stall_result", gr, 16'h5555);

      do_op(16'hFFFF, 16'hFFFF, OP_ADD, 0, gr, gs, ge, glat);
      chk("pre_rst_status_nonzero", 64'(gs != 6'b0), 1);

      // Abort a long shift with reset two cycles after acceptance
      A = 16'hFFFF; B = 16'd8; F = OP_SHR; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; mst = '0;
      chk("abort_out_valid", out_valid, 0);
      chk("abort_status", Status, 0);
      chk("abort_in_ready", in_ready, 1);
      repeat (12) begin
         @(negedge clk);
         chk("abort_no_result", out_valid, 0);
      end

      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(9) == 0) fop = bad_ops[$urandom_range(5)];
         else fop = legal_ops[$urandom_range(17)];
         do_op(16'($urandom), 16'($urandom), fop, int'($urandom_range(2)), gr, gs, ge, glat);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

endmodule
